// File: rtl/multiport_register_file.sv
// Multi-ported general-purpose register file for the CPU datapath.
// Every read port is registered with its own enable. A read sees the value the
// register holds after the same edge's writes (write-through bypass). When two
// or more write ports hit the same address, the lowest-indexed port wins and
// WriteConflict pulses high for one cycle. No valid/ready handshake: every
// enabled port is serviced on every edge and nothing ever stalls.
module multiport_register_file #(
   parameter int  DATA_W    = 32,
   parameter int  DEPTH     = 32,
   parameter int  NUM_READ  = 2,
   parameter int  NUM_WRITE = 2,
   parameter int  ZERO_REG  = 1,
   parameter int  SP_INDEX  = 29,
   parameter int  SP_INIT   = 252,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [NUM_READ-1:0]           ReadEnable,
   input  logic [NUM_READ*ADDR_W-1:0]    ReadRegister,
   output logic [NUM_READ*DATA_W-1:0]    ReadData,
   input  logic [NUM_WRITE-1:0]          RegWrite,
   input  logic [NUM_WRITE*ADDR_W-1:0]   WriteRegister,
   input  logic [NUM_WRITE*DATA_W-1:0]   WriteData,
   output logic                          WriteConflict
);

   logic [DATA_W-1:0]          regs_q [DEPTH];
   logic [DATA_W-1:0]          regs_d [DEPTH];
   logic [NUM_READ*DATA_W-1:0] rd_q, rd_d;
   logic                       conflict_q, conflict_d;
   logic [NUM_WRITE-1:0]       wr_eff;

   // A write port is effective unless it is idle or targets the hardwired zero register.
   always_comb begin
      wr_eff = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
         wr_eff[j] = RegWrite[j] &&
                     !((ZERO_REG != 0) && (WriteRegister[j*ADDR_W +: ADDR_W] == '0));
      end
   end

   // Post-write register image; ports are applied highest index first so the
   // lowest-indexed port overrides on a collision.
   always_comb begin
      regs_d = regs_q;
      for (int j = NUM_WRITE - 1; j >= 0; j--) begin
         if (wr_eff[j]) begin
            regs_d[WriteRegister[j*ADDR_W +: ADDR_W]] = WriteData[j*DATA_W +: DATA_W];
         end
      end
   end

   // Collision detect: any pair of effective ports sharing an address.
   always_comb begin
      conflict_d = 1'b0;
      for (int j = 1; j < NUM_WRITE; j++) begin
         for (int k = 0; k < j; k++) begin
            if (wr_eff[j] && wr_eff[k] &&
                (WriteRegister[j*ADDR_W +: ADDR_W] == WriteRegister[k*ADDR_W +: ADDR_W])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Read ports sample the post-write image; a disabled port holds its last value.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      ra   = '0;
      rd_d = rd_q;
      for (int i = 0; i < NUM_READ; i++) begin
         ra = ReadRegister[i*ADDR_W +: ADDR_W];
         if (ReadEnable[i]) begin
            if ((ZERO_REG != 0) && (ra == '0)) begin
               rd_d[i*DATA_W +: DATA_W] = '0;
            end else begin
               rd_d[i*DATA_W +: DATA_W] = regs_d[ra];
            end
         end
      end
   end

   // State update; reset clears everything except the stack pointer register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= (k == SP_INDEX) ? DATA_W'(SP_INIT) : '0;
         end
         rd_q       <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         rd_q       <= rd_d;
         conflict_q <= conflict_d;
      end
   end

   assign ReadData      = rd_q;
   assign WriteConflict = conflict_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: a default 32x32 2R/2W instance
// driven from a vector table, plus a 16-bit 8-entry 3R/3W instance without a
// zero register exercised by a hand-written sequence.
module tb_multiport_register_file;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic        rst;
   logic [1:0]  ren;
   logic [9:0]  rra;
   logic [63:0] rd;
   logic [1:0]  we;
   logic [9:0]  wra;
   logic [63:0] wd;
   logic        conf;

   multiport_register_file dut_a (
      .Clk(clk), .Reset(rst),
      .ReadEnable(ren), .ReadRegister(rra), .ReadData(rd),
      .RegWrite(we), .WriteRegister(wra), .WriteData(wd),
      .WriteConflict(conf)
   );

   // small instance: DATA_W=16, DEPTH=8, 3R/3W, ZERO_REG=0 (SP_INDEX 29 out of range)
   logic        rst_b;
   logic [2:0]  ren_b;
   logic [8:0]  rra_b;
   logic [47:0] rd_b;
   logic [2:0]  we_b;
   logic [8:0]  wra_b;
   logic [47:0] wd_b;
   logic        conf_b;

   multiport_register_file #(
      .DATA_W(16), .DEPTH(8), .NUM_READ(3), .NUM_WRITE(3), .ZERO_REG(0)
   ) dut_b (
      .Clk(clk), .Reset(rst_b),
      .ReadEnable(ren_b), .ReadRegister(rra_b), .ReadData(rd_b),
      .RegWrite(we_b), .WriteRegister(wra_b), .WriteData(wd_b),
      .WriteConflict(conf_b)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  ren;
      logic [4:0]  ra0, ra1;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [31:0] e_rd0, e_rd1;
      logic        e_conf;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input logic [1:0] r_en, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [1:0] w_en, input logic [4:0] w0, input logic [4:0] w1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] e0, input logic [31:0] e1, input logic ec);
      vec_t v;
      v.ren = r_en; v.ra0 = a0; v.ra1 = a1;
      v.we = w_en; v.wa0 = w0; v.wa1 = w1; v.wd0 = d0; v.wd1 = d1;
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_conf = ec;
      vq.push_back(v);
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                        input logic ec);
      n_vec++;
      chk({nm, " rd0"}, rd[31:0], e0);
      chk({nm, " rd1"}, rd[63:32], e1);
      chk({nm, " conf"}, {31'd0, conf}, {31'd0, ec});
   endtask

   task automatic chk_b(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic ec);
      n_vec++;
      chk({nm, " rd0"}, {16'd0, rd_b[15:0]}, {16'd0, e0});
      chk({nm, " rd1"}, {16'd0, rd_b[31:16]}, {16'd0, e1});
      chk({nm, " rd2"}, {16'd0, rd_b[47:32]}, {16'd0, e2});
      chk({nm, " conf"}, {31'd0, conf_b}, {31'd0, ec});
   endtask

   // ---------------- drivers ----------------
   task automatic drive_a(input vec_t v);
      ren = v.ren; rra = {v.ra1, v.ra0};
      we  = v.we;  wra = {v.wa1, v.wa0}; wd = {v.wd1, v.wd0};
   endtask

   task automatic step_b(input logic [2:0] r_en, input logic [2:0] a2, input logic [2:0] a1,
                         input logic [2:0] a0, input logic [2:0] w_en,
                         input logic [2:0] w2, input logic [2:0] w1, input logic [2:0] w0,
                         input logic [15:0] d2, input logic [15:0] d1, input logic [15:0] d0);
      ren_b = r_en; rra_b = {a2, a1, a0};
      we_b  = w_en; wra_b = {w2, w1, w0}; wd_b = {d2, d1, d0};
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; ren = '0; rra = '0; we = '0; wra = '0; wd = '0;
      rst_b = 1'b1; ren_b = '0; rra_b = '0; we_b = '0; wra_b = '0; wd_b = '0;

      // register/read/expected table for the default instance
      //   ren    ra0    ra1    we     wa0    wa1    wd0           wd1           e_rd0         e_rd1         conf
      add(2'b11, 5'd29, 5'd5,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'd252,      32'd0,        1'b0);
      add(2'b00, 5'd0,  5'd0,  2'b11, 5'd3,  5'd4,  32'hDEADBEEF, 32'h12345678, 32'd252,      32'd0,        1'b0);
      add(2'b11, 5'd3,  5'd4,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0);
      add(2'b00, 5'd1,  5'd2,  2'b11, 5'd7,  5'd7,  32'hAAAA0000, 32'h0000BBBB, 32'hDEADBEEF, 32'h12345678, 1'b1);
      add(2'b01, 5'd7,  5'd2,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'hAAAA0000, 32'h12345678, 1'b0);
      add(2'b01, 5'd9,  5'd1,  2'b01, 5'd9,  5'd0,  32'h55,       32'h0,        32'h55,       32'h12345678, 1'b0);
      add(2'b11, 5'd10, 5'd10, 2'b11, 5'd10, 5'd10, 32'h111,      32'h222,      32'h111,      32'h111,      1'b1);
      add(2'b11, 5'd0,  5'd0,  2'b11, 5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0);
      add(2'b00, 5'd3,  5'd4,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
      add(2'b10, 5'd3,  5'd29, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd252,      1'b0);
      add(2'b11, 5'd5,  5'd29, 2'b11, 5'd5,  5'd29, 32'hA5A5,     32'h100,      32'hA5A5,     32'h100,      1'b0);
      add(2'b11, 5'd12, 5'd0,  2'b11, 5'd12, 5'd0,  32'hC,        32'hD,        32'hC,        32'h0,        1'b0);
      add(2'b11, 5'd9,  5'd7,  2'b11, 5'd13, 5'd13, 32'h1,        32'h2,        32'h55,       32'hAAAA0000, 1'b1);

      // reset state: reads requested during reset are ignored
      ren = 2'b11; rra = {5'd5, 5'd29};
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", 32'h0, 32'h0, 1'b0);
      rst = 1'b0;

      foreach (vq[i]) begin
         drive_a(vq[i]);
         @(posedge clk); #1;
         chk_a($sformatf("v%0d", i), vq[i].e_rd0, vq[i].e_rd1, vq[i].e_conf);
      end

      // reset mid-cycle with writes pending: outputs clear before any edge
      we = 2'b11; wra = {5'd29, 5'd3}; wd = {32'h1, 32'hBAD};
      ren = 2'b11; rra = {5'd3, 5'd29};
      #3 rst = 1'b1;
      #1 chk_a("async_rst", 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk_a("rst_hold", 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      we = 2'b00; ren = 2'b11; rra = {5'd3, 5'd29};
      @(posedge clk); #1;
      chk_a("post_rst", 32'd252, 32'h0, 1'b0);
      rra = {5'd9, 5'd13};
      @(posedge clk); #1;
      chk_a("post_rst_clr", 32'h0, 32'h0, 1'b0);
      ren = 2'b00; we = 2'b00;

      // small instance without zero register
      rst_b = 1'b0;
      //     ren     ra2   ra1   ra0   we      w2    w1    w0    d2        d1        d0
      step_b(3'b111, 3'd7, 3'd5, 3'd0, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0,    16'h0,    16'h0);
      chk_b("b_reset", 16'h0, 16'h0, 16'h0, 1'b0);
      step_b(3'b111, 3'd0, 3'd0, 3'd0, 3'b111, 3'd0, 3'd0, 3'd0, 16'h3333, 16'h2222, 16'h1111);
      chk_b("b_r0_3way", 16'h1111, 16'h1111, 16'h1111, 1'b1);
      step_b(3'b111, 3'd0, 3'd6, 3'd5, 3'b111, 3'd5, 3'd5, 3'd6, 16'hCAFE, 16'hBEEF, 16'h0606);
      chk_b("b_p1_wins", 16'hBEEF, 16'h0606, 16'h1111, 1'b1);
      step_b(3'b100, 3'd5, 3'd1, 3'd2, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0,    16'h0,    16'h0);
      chk_b("b_hold", 16'hBEEF, 16'h0606, 16'hBEEF, 1'b0);
      step_b(3'b011, 3'd1, 3'd3, 3'd7, 3'b111, 3'd7, 3'd3, 3'd7, 16'hFFFF, 16'h0303, 16'h7070);
      chk_b("b_p0_vs_p2", 16'h7070, 16'h0303, 16'hBEEF, 1'b1);
      step_b(3'b111, 3'd0, 3'd7, 3'd6, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0,    16'h0,    16'h0);
      chk_b("b_readback", 16'h0606, 16'h7070, 16'h1111, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
